// File: rtl/uart_pkg.sv
// Shared UART definitions: mode encoding, receiver states and the baud/divisor table
// used by both the TX and RX blocks so their rates always agree.
package uart_pkg;

  localparam int unsigned OS_FACTOR = 16;
  localparam int unsigned NUM_MODES = 16;

  typedef logic [3:0] mode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam int unsigned BAUD_TABLE [NUM_MODES] = '{
    9600, 19200, 38400, 57600, 115200,
    9600, 9600, 9600, 9600, 9600, 9600,
    9600, 9600, 9600, 9600, 9600
  };

  // Oversample divisor rounded to nearest: round(clk_freq / (16 * baud)).
  function automatic int unsigned os_div(input int unsigned clk_freq, input mode_t m);
    int unsigned den;
    den = OS_FACTOR * BAUD_TABLE[m];
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: counts 0..div-1 and flags the div-1 cycle.
// The flag is registered from the next count so it lines up with count == div-1.
module uart_os_tick #(
  parameter int unsigned DIV_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             os_tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_n;
  logic [DIV_W-1:0] last_c;

  assign last_c = div - DIV_W'(1);

  always_comb begin
    cnt_n = cnt_q + DIV_W'(1);
    if (clr || (cnt_q >= last_c)) begin
      cnt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      os_tick <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      os_tick <= (cnt_n == last_c);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling 8N1 UART receiver with 3-sample majority vote per bit,
// start-glitch rejection, framing-error reporting and break hold-off.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned OS_RATE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  mode_t      mode,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV_W  = $clog2(os_div(CLK_FREQ, mode_t'(0)) + 1);
  localparam int unsigned TICK_W = $clog2(OS_RATE);
  localparam logic [TICK_W-1:0] SMP_A = TICK_W'(OS_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] SMP_B = TICK_W'(OS_RATE / 2);
  localparam logic [TICK_W-1:0] SMP_C = TICK_W'(OS_RATE / 2 + 1);
  localparam logic [TICK_W-1:0] LAST  = TICK_W'(OS_RATE - 1);

  logic              rx_m;
  logic              rx_s;
  logic              os_tick;
  logic              maj_c;
  logic              clr_c;
  logic [DIV_W-1:0]  div_c;
  logic [DIV_W-1:0]  div_tab [NUM_MODES];

  state_t            state_q, state_n;
  mode_t             mode_q, mode_n;
  logic [TICK_W-1:0] tick_q, tick_n;
  logic [2:0]        bit_q, bit_n;
  logic [7:0]        shift_q, shift_n;
  logic              smp_a_q, smp_a_n;
  logic              smp_b_q, smp_b_n;
  logic [7:0]        data_n;
  logic              dv_n, fe_n, busy_n;

  // Divisors are elaboration-time constants per mode; only the lookup is hardware.
  for (genvar g = 0; g < NUM_MODES; g++) begin : g_div
    assign div_tab[g] = DIV_W'(os_div(CLK_FREQ, mode_t'(g)));
  end

  assign div_c = div_tab[mode_q];
  assign clr_c = (state_q == IDLE);
  assign maj_c = (smp_a_q & smp_b_q) | (smp_a_q & rx_s) | (smp_b_q & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_line;
      rx_s <= rx_m;
    end
  end

  uart_os_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_c),
    .div     (div_c),
    .os_tick (os_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      smp_a_q    <= 1'b1;
      smp_b_q    <= 1'b1;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      tick_q     <= tick_n;
      bit_q      <= bit_n;
      shift_q    <= shift_n;
      smp_a_q    <= smp_a_n;
      smp_b_q    <= smp_b_n;
      data       <= data_n;
      data_valid <= dv_n;
      frame_err  <= fe_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    smp_a_n = smp_a_q;
    smp_b_n = smp_b_q;
    data_n  = data;
    dv_n    = 1'b0;
    fe_n    = 1'b0;

    // Tick position and the two early vote samples are common to all bit-timed states.
    if (os_tick && (state_q inside {START, DATA, STOP})) begin
      tick_n = tick_q + TICK_W'(1);
      if (tick_q == SMP_A) smp_a_n = rx_s;
      if (tick_q == SMP_B) smp_b_n = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          mode_n  = mode;
          tick_n  = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (os_tick) begin
          if ((tick_q == SMP_C) && maj_c) begin
            state_n = IDLE;
          end else if (tick_q == LAST) begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          if (tick_q == SMP_C) begin
            shift_n = {maj_c, shift_q[7:1]};
          end
          if (tick_q == LAST) begin
            bit_n = bit_q + 3'd1;
            if (bit_q == 3'd7) state_n = STOP;
          end
        end
      end
      // Leave at mid-stop so a back-to-back start edge is not missed.
      STOP: begin
        if (os_tick && (tick_q == SMP_C)) begin
          if (maj_c) begin
            data_n  = shift_q;
            dv_n    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: framing, majority vote, glitch/break handling,
// back-to-back frames, reset mid-frame and end-to-end latency.
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic [3:0] mode = 4'd4;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int t0 = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  int dv_cyc = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;
  logic [7:0] dq [$];

  localparam int DIV4 = 27;   // 50 MHz / (16 * 115200), rounded
  localparam int DIV1 = 163;  // 50 MHz / (16 * 19200), rounded

  uart_rx_os #(
    .CLK_FREQ (50_000_000),
    .OS_RATE  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_line    (rx_line),
    .mode       (mode),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        dv_cnt <= dv_cnt + 1;
        dv_cyc <= cyc;
        dq.push_back(data);
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (data_valid && frame_err) both_cnt <= both_cnt + 1;
      if ((data_valid && prev_dv) || (frame_err && prev_fe)) long_cnt <= long_cnt + 1;
    end
    prev_dv <= data_valid;
    prev_fe <= frame_err;
  end

  task automatic hold(input logic lvl, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx_line = lvl;
    end
  endtask

  // Drives start, 8 data bits LSB first, stop; optional one-cycle inversion at the
  // tick-8 sample point of every data bit; limit > 0 aborts after that many cycles.
  task automatic drive_frame(input logic [7:0] b, input int div, input logic stop_v,
                             input bit glitch, input int limit);
    int c;
    logic v;
    c = 0;
    for (int bi = 0; bi < 10; bi++) begin
      if (bi == 0) v = 1'b0;
      else if (bi == 9) v = stop_v;
      else v = b[bi-1];
      for (int k = 0; k < 16 * div; k++) begin
        if (limit > 0 && c >= limit) return;
        @(posedge clk);
        #1;
        if (c == 0) t0 = cyc;
        rx_line = (glitch && bi >= 1 && bi <= 8 && k == 9 * div) ? ~v : v;
        c++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1;
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    hold(1'b1, 20);
  endtask

  task automatic test_single_a5();
    int dv0, fe0, lat;
    dv0 = dv_cnt; fe0 = fe_cnt;
    mode = 4'd4;
    fork
      drive_frame(8'hA5, DIV4, 1'b1, 1'b0, 0);
      begin
        repeat (300) @(posedge clk);
        #1 mode = 4'd0;
      end
    join
    hold(1'b1, 40);
    lat = dv_cyc - t0;
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL a5_dv_count: got %0d want 1", dv_cnt - dv0); end
    total++; if (data !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", data); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL a5_fe_count: got %0d want 0", fe_cnt - fe0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy_after: got %b want 0", busy); end
    total++; if (lat < 154 * DIV4 + 1 || lat > 154 * DIV4 + 3) begin
      bad++; $display("FAIL a5_latency: got %0d want %0d..%0d", lat, 154 * DIV4 + 1, 154 * DIV4 + 3);
    end
    mode = 4'd4;
  endtask

  task automatic test_start_glitch();
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    hold(1'b0, 135);
    hold(1'b1, 115);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    hold(1'b1, 30);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL glitch_dv_count: got %0d want 0", dv_cnt - dv0); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL glitch_fe_count: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    int dv0, fe0;
    logic [7:0] d0, d1;
    dv0 = dv_cnt; fe0 = fe_cnt;
    mode = 4'd1;
    drive_frame(8'h00, DIV1, 1'b1, 1'b0, 0);
    drive_frame(8'hFF, DIV1, 1'b1, 1'b0, 0);
    hold(1'b1, 200);
    d0 = 8'hxx; d1 = 8'hxx;
    if (dq.size() >= 2) begin
      d0 = dq[dq.size() - 2];
      d1 = dq[dq.size() - 1];
    end
    total++; if (dv_cnt - dv0 !== 2) begin bad++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - dv0); end
    total++; if (d0 !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", d0); end
    total++; if (d1 !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", d1); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL b2b_fe_count: got %0d want 0", fe_cnt - fe0); end
    mode = 4'd4;
  endtask

  task automatic test_break();
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_frame(8'h3C, DIV4, 1'b0, 1'b0, 0);
    hold(1'b0, 3 * 16 * DIV4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_held: got %b want 1", busy); end
    hold(1'b1, 60);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL break_fe_count: got %0d want 1", fe_cnt - fe0); end
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL break_dv_count: got %0d want 0", dv_cnt - dv0); end
    total++; if (data !== 8'hFF) begin bad++; $display("FAIL break_data_kept: got %h want ff", data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_majority();
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_frame(8'h5A, DIV4, 1'b1, 1'b1, 0);
    hold(1'b1, 40);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL maj_dv_count: got %0d want 1", dv_cnt - dv0); end
    total++; if (data !== 8'h5A) begin bad++; $display("FAIL maj_data: got %h want 5a", data); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL maj_fe_count: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, fe0;
    // Abort halfway through data bit 4 (frame bit index 5).
    drive_frame(8'h81, DIV4, 1'b1, 1'b0, 5 * 16 * DIV4 + 8 * DIV4);
    @(posedge clk);
    #1 begin rst = 1'b1; rx_line = 1'b1; end
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", data); end
    rst = 1'b0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    hold(1'b1, 20);
    total++; if (dv_cnt - dv0 !== 0) begin bad++; $display("FAIL rst_no_partial: got %0d want 0", dv_cnt - dv0); end
    drive_frame(8'h42, DIV4, 1'b1, 1'b0, 0);
    hold(1'b1, 40);
    total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL rst_next_dv: got %0d want 1", dv_cnt - dv0); end
    total++; if (data !== 8'h42) begin bad++; $display("FAIL rst_next_data: got %h want 42", data); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL rst_next_fe: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_pulse_rules();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_exclusive: got %0d want 0", both_cnt); end
    total++; if (long_cnt !== 0) begin bad++; $display("FAIL pulse_width: got %0d want 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_start_glitch();
    test_back_to_back();
    test_break();
    test_majority();
    test_reset_mid_frame();
    test_pulse_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
